// File: rtl/trace_pkg.sv
// Shared types and constants for the execution-trace UART.
// TRACE_PARITY_EN selects 8E1 framing (adds a PARITY state); default is 8N1.
package trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int DATA_BITS = 8;

`ifdef TRACE_PARITY_EN
  localparam int FRAME_BITS = 11;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/trace_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with explicit occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/trace_uart_tx.sv
// Captures {instr, rVal} per processor cycle and serializes each pair as two UART frames.
// TRACE_PARITY_EN inserts an even-parity bit per frame; default is plain 8N1.
module trace_uart_tx
  import trace_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 instr,
  input  logic [7:0]                 rVal,
  input  logic                       capture_en,
  output logic                       tx,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic            byte_sel;
  logic [15:0]     hold;
  logic [15:0]     rdata;
  logic            full;
  logic            empty;
  logic            tick;
  logic            pop;
  logic [7:0]      cur_byte;

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (capture_en),
    .pop   (pop),
    .wdata ({instr, rVal}),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign tick     = (timer == TW'(CLKS_PER_BIT-1));
  assign cur_byte = byte_sel ? hold[7:0] : hold[15:8];
  assign busy     = (state != ST_IDLE);
  // The end of the second STOP doubles as a pop slot so entries stream without an idle bit.
  assign pop      = !empty && ((state == ST_IDLE) || (state == ST_STOP && tick && byte_sel));

  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!empty) state_nxt = ST_START;
      end
      ST_START: begin
        tx = 1'b0;
        if (tick) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx = cur_byte[bit_idx];
        if (tick && bit_idx == 3'(DATA_BITS-1)) begin
`ifdef TRACE_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef TRACE_PARITY_EN
      ST_PARITY: begin
        tx = even_parity(cur_byte);
        if (tick) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (!byte_sel || !empty) state_nxt = ST_START;
          else                     state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
      hold     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE || tick) timer <= '0;
      else                          timer <= timer + TW'(1);
      if (state != ST_DATA) bit_idx <= '0;
      else if (tick)        bit_idx <= bit_idx + 3'd1;
      if (state == ST_STOP && tick) byte_sel <= ~byte_sel;
      if (pop) hold <= rdata;
      if (capture_en && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trace_uart_tx.sv
// Directed bench for trace_uart_tx with DEPTH=4, CLKS_PER_BIT=4.
// Honours TRACE_PARITY_EN when the build defines it.
module tb_trace_uart_tx;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef TRACE_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int ENTRY = 2 * FB * CPB;

  logic       clk;
  logic       reset;
  logic [7:0] instr;
  logic [7:0] rVal;
  logic       capture_en;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] count;

  int checks;
  int errors;
  logic [15:0] exp_q[$];

  trace_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .rVal       (rVal),
    .capture_en (capture_en),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .count      (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [7:0] i_v, input logic [7:0] r_v);
    capture_en = 1'b1;
    instr      = i_v;
    rVal       = r_v;
    step(1);
    capture_en = 1'b0;
  endtask

  // Line level q cycles after the pop of pair {ins, rv}.
  function automatic logic exp_tx(input logic [7:0] ins, input logic [7:0] rv, input int q);
    int fi;
    int bi;
    logic [7:0] b;
    logic [7:0] sh;
    fi = q / (FB * CPB);
    bi = (q % (FB * CPB)) / CPB;
    b  = (fi == 0) ? ins : rv;
    if (bi == 0) return 1'b0;
    if (bi <= 8) begin
      sh = b >> (bi - 1);
      return sh[0];
    end
`ifdef TRACE_PARITY_EN
    if (bi == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // scoreboard: check every cycle of the queued pairs, starting j0 cycles after the first pop
  task automatic drain(input int j0);
    int total;
    logic [15:0] pair;
    total = exp_q.size() * ENTRY;
    for (int j = j0; j < total; j++) begin
      pair = exp_q[j / ENTRY];
      check("drain_tx", 32'(tx), 32'(exp_tx(pair[15:8], pair[7:0], j % ENTRY)));
      check("drain_busy", 32'(busy), 1);
      step(1);
    end
    exp_q.delete();
  endtask

  logic [7:0] ins_tab [6] = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hE5, 8'h66};
  logic [7:0] rv_tab  [6] = '{8'h18, 8'h7E, 8'h00, 8'hFF, 8'h5A, 8'h99};
  logic [2:0] cnt_tab [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
  logic       ovf_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    checks     = 0;
    errors     = 0;
    capture_en = 1'b0;
    instr      = '0;
    rVal       = '0;

    // reset state and quiet idle
    do_reset();
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ovf", 32'(overflow), 0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_tx", 32'(tx), 1);
      check("idle_busy", 32'(busy), 0);
      check("idle_count", 32'(count), 0);
      check("idle_ovf", 32'(overflow), 0);
    end

    // single entry A5/3C
    capture(8'hA5, 8'h3C);
    check("single_count_push", 32'(count), 1);
    check("single_busy_pre", 32'(busy), 0);
    check("single_tx_pre", 32'(tx), 1);
    step(1);
    check("single_count_pop", 32'(count), 0);
    exp_q.push_back(16'hA53C);
    drain(0);
    check("single_busy_end", 32'(busy), 0);
    check("single_tx_end", 32'(tx), 1);

    // full FIFO with push on the pop edge
    do_reset();
    for (int i = 0; i < 5; i++) capture(ins_tab[i], rv_tab[i]);
    check("fullpop_count_fill", 32'(count), 4);
    check("fullpop_ovf_fill", 32'(overflow), 0);
    step(ENTRY - 4);
    check("fullpop_count_wait", 32'(count), 4);
    capture(8'h77, 8'h88);
    check("fullpop_count_edge", 32'(count), 4);
    check("fullpop_ovf_edge", 32'(overflow), 0);
    check("fullpop_tx_start", 32'(tx), 0);
    check("fullpop_busy", 32'(busy), 1);
    step(1);
    check("fullpop_count_after", 32'(count), 4);

    // overflow: six consecutive captures into DEPTH=4
    do_reset();
    capture_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      instr = ins_tab[i];
      rVal  = rv_tab[i];
      step(1);
      check("ovf_count", 32'(count), 32'(cnt_tab[i]));
      check("ovf_flag", 32'(overflow), 32'(ovf_tab[i]));
      if (i < 5) exp_q.push_back({ins_tab[i], rv_tab[i]});
    end
    capture_en = 1'b0;
    drain(4);
    check("ovf_busy_end", 32'(busy), 0);
    check("ovf_tx_end", 32'(tx), 1);
    check("ovf_count_end", 32'(count), 0);
    check("ovf_flag_sticky", 32'(overflow), 1);

    // reset in the middle of the first data byte
    do_reset();
    capture(8'h11, 8'h22);
    capture(8'h33, 8'h44);
    check("midrst_count_pre", 32'(count), 1);
    step(10);
    check("midrst_busy_pre", 32'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_count", 32'(count), 0);
    check("midrst_ovf", 32'(overflow), 0);
    step(2);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      check("midrst_quiet_tx", 32'(tx), 1);
      check("midrst_quiet_busy", 32'(busy), 0);
      check("midrst_quiet_count", 32'(count), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
